// File: rtl/riscv_multiciclo_controle.sv
// Main control FSM of the multicycle RV32I core: sequences the shared memory, ALU,
// register file and PC/IR/ALUOut registers, with memory wait-states and an illegal-opcode trap.
module riscv_multiciclo_controle #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] funct_alu;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= state_t'(RESET_STATE);
    else        state_reg <= state_next;
  end

  // funct3/funct7 ALU decode; subtraction only for R-type (opcode[5] set), never addi.
  always_comb begin
    funct_alu = 3'b000;
    case (funct3)
      3'b000:  funct_alu = (funct7_5 & opcode[5]) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_next    = S_FETCH;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    illegal       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_next   = S_DECODE;
        end else begin
          state_next   = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      // PC takes the target computed into ALUOut during DECODE; ALU forms OldPC+4 for rd.
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_control  = 3'b001;
        pc_write_raw = zero;
        state_next   = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are held off for the whole time reset is asserted, not just at the edge.
  assign pc_write  = pc_write_raw  & reset;
  assign ir_write  = ir_write_raw  & reset;
  assign reg_write = reg_write_raw & reset;
  assign mem_write = mem_write_raw & reset;
  assign state_out = state_reg;

endmodule

// File: tb/tb_riscv_multiciclo_controle.sv
// Scoreboard bench for riscv_multiciclo_controle: each driven cycle queues the hand-computed
// expected outputs, and a negedge monitor pops and compares them.
module tb_riscv_multiciclo_controle;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_out;

  riscv_multiciclo_controle #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [8:0]  core;   // {state, pc_write, ir_write, reg_write, mem_write, illegal}
    logic        chk;
    logic [11:0] mux;    // {adr_src, result_src, a, b, alu_control, imm_src}
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mux_pend = 1'b0;
  logic [11:0] mux_val  = '0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0]  act_core;
      logic [11:0] act_mux;
      e = exp_q.pop_front();
      act_core = {state_out, pc_write, ir_write, reg_write, mem_write, illegal};
      act_mux  = {adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src};
      n_checks++;
      if (act_core !== e.core) begin
        n_fail++;
        $display("FAIL %s core: got st=%0d pw/iw/rw/mw/ill=%b, want st=%0d %b",
                 e.name, act_core[8:5], act_core[4:0], e.core[8:5], e.core[4:0]);
      end else
        $display("ok   %s st=%0d strobes=%b", e.name, act_core[8:5], act_core[4:0]);
      if (e.chk) begin
        n_checks++;
        if (act_mux !== e.mux) begin
          n_fail++;
          $display("FAIL %s mux: got adr/res/a/b/alu/imm=%b, want %b", e.name, act_mux, e.mux);
        end
      end
    end
  end

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct7_5 = f75;
  endtask

  task automatic mux(input logic adr, input logic [1:0] rs, input logic [1:0] a,
                     input logic [1:0] b, input logic [2:0] alu, input logic [1:0] imm);
    mux_pend = 1'b1;
    mux_val  = {adr, rs, a, b, alu, imm};
  endtask

  // sb = {pc_write, ir_write, reg_write, mem_write, illegal}
  task automatic cyc(input string name, input logic mr, input logic z,
                     input logic [3:0] st, input logic [4:0] sb);
    exp_t e;
    mem_ready = mr;
    zero      = z;
    e.name = name; e.core = {st, sb}; e.chk = mux_pend; e.mux = mux_val;
    mux_pend = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    @(posedge clk); #1;

    // reset held with mem_ready=1: FETCH but no strobes
    mux(1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("rst0", 1, 0, 4'd0, 5'b00000);
    cyc("rst1", 1, 0, 4'd0, 5'b00000);
    reset = 1'b1;

    // lw
    cyc("lw_fetch", 1, 0, 4'd0, 5'b11000);
    mux(1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("lw_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc("lw_adr", 1, 0, 4'd2, 5'b00000);
    mux(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("lw_rd", 1, 0, 4'd3, 5'b00000);
    mux(1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("lw_wb", 1, 0, 4'd4, 5'b00100);

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("sw_dec", 1, 0, 4'd1, 5'b00000);
    cyc("sw_adr", 1, 0, 4'd2, 5'b00000);
    mux(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc("sw_wr", 1, 0, 4'd5, 5'b00010);

    // addi
    set_instr(7'b0010011, 3'b000, 1'b0);
    cyc("addi_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("addi_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc("addi_ex", 1, 0, 4'd8, 5'b00000);
    mux(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("addi_wb", 1, 0, 4'd7, 5'b00100);

    // R-type ALU decode
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("sub_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00);
    cyc("sub_ex", 1, 0, 4'd6, 5'b00000);
    cyc("sub_wb", 1, 0, 4'd7, 5'b00100);

    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("and_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00);
    cyc("and_ex", 1, 0, 4'd6, 5'b00000);
    cyc("and_wb", 1, 0, 4'd7, 5'b00100);

    set_instr(7'b0110011, 3'b110, 1'b0);
    cyc("or_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("or_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00);
    cyc("or_ex", 1, 0, 4'd6, 5'b00000);
    cyc("or_wb", 1, 0, 4'd7, 5'b00100);

    set_instr(7'b0110011, 3'b010, 1'b0);
    cyc("slt_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("slt_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00);
    cyc("slt_ex", 1, 0, 4'd6, 5'b00000);
    cyc("slt_wb", 1, 0, 4'd7, 5'b00100);

    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi7_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("addi7_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc("addi7_ex", 1, 0, 4'd8, 5'b00000);
    cyc("addi7_wb", 1, 0, 4'd7, 5'b00100);

    // beq taken / not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc("beq1_fetch", 1, 1, 4'd0, 5'b11000);
    cyc("beq1_dec", 1, 1, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
    cyc("beq1_br", 1, 1, 4'd10, 5'b10000);
    cyc("beq0_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("beq0_dec", 1, 0, 4'd1, 5'b00000);
    cyc("beq0_br", 1, 0, 4'd10, 5'b00000);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("jal_dec", 1, 0, 4'd1, 5'b00000);
    mux(1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11);
    cyc("jal_j", 1, 0, 4'd9, 5'b10000);
    cyc("jal_wb", 1, 0, 4'd7, 5'b00100);

    // FETCH wait-states
    set_instr(7'b0010011, 3'b000, 1'b0);
    cyc("fw_wait0", 0, 0, 4'd0, 5'b00000);
    cyc("fw_wait1", 0, 0, 4'd0, 5'b00000);
    cyc("fw_wait2", 0, 0, 4'd0, 5'b00000);
    cyc("fw_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("fw_dec", 1, 0, 4'd1, 5'b00000);
    cyc("fw_ex", 1, 0, 4'd8, 5'b00000);
    cyc("fw_wb", 1, 0, 4'd7, 5'b00100);

    // MEMWRITE wait-states
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sww_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("sww_dec", 1, 0, 4'd1, 5'b00000);
    cyc("sww_adr", 1, 0, 4'd2, 5'b00000);
    cyc("sww_wr0", 0, 0, 4'd5, 5'b00010);
    cyc("sww_wr1", 0, 0, 4'd5, 5'b00010);
    cyc("sww_wr2", 1, 0, 4'd5, 5'b00010);

    // MEMREAD wait-state
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lww_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("lww_dec", 1, 0, 4'd1, 5'b00000);
    cyc("lww_adr", 1, 0, 4'd2, 5'b00000);
    cyc("lww_rd0", 0, 0, 4'd3, 5'b00000);
    cyc("lww_rd1", 1, 0, 4'd3, 5'b00000);
    cyc("lww_wb", 1, 0, 4'd4, 5'b00100);

    // illegal opcode: sticky trap
    set_instr(7'b1110011, 3'b000, 1'b0);
    cyc("trap_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("trap_dec", 1, 0, 4'd1, 5'b00000);
    for (int i = 0; i < 10; i++) cyc($sformatf("trap%0d", i), i[0], 0, 4'd11, 5'b00001);
    reset = 1'b0;
    cyc("trap_rst", 1, 0, 4'd0, 5'b00000);
    reset = 1'b1;

    // asynchronous reset in the middle of MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("swr_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("swr_dec", 1, 0, 4'd1, 5'b00000);
    cyc("swr_adr", 0, 0, 4'd2, 5'b00000);
    cyc("swr_wr", 0, 0, 4'd5, 5'b00010);
    reset = 1'b0;
    cyc("swr_rst0", 0, 0, 4'd0, 5'b00000);
    cyc("swr_rst1", 1, 0, 4'd0, 5'b00000);
    reset = 1'b1;
    cyc("post_fetch", 1, 0, 4'd0, 5'b11000);
    cyc("post_dec", 1, 0, 4'd1, 5'b00000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
